// File: rtl/uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// uart_echo_buffer
//   FIFO-buffered echo path between uart_rx and uart_tx. Received bytes are
//   queued so that none are lost while the transmitter is busy. The block can
//   hold output until a complete line has arrived (LINE_MODE), can fold lower
//   case letters to upper case on the way out (UPPERCASE), and counts the
//   bytes it had to drop.
//
// Ports
//   clk, rst_n     : system clock, asynchronous active-low reset
//   rx_data/_valid : byte strobe from uart_rx
//   rx_data_ready  : constant 1, uart_rx is never back-pressured
//   tx_data/_valid : registered byte to uart_tx
//   tx_data_ready  : uart_tx accepts the byte
//   ovf_clr        : synchronous clear of ovf_count
//   fifo_count     : current FIFO occupancy
//   ovf_count      : saturating count of dropped bytes
//   fifo_full      : fifo_count == FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_echo_buffer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter int                    LINE_MODE  = 0,
    parameter logic [DATA_WIDTH-1:0] LINE_TERM  = DATA_WIDTH'(8'h0D),
    parameter int                    UPPERCASE  = 0,
    parameter int                    OVF_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_data_valid,
    output logic                          rx_data_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_data_ready,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [OVF_W-1:0]              ovf_count,
    output logic                          fifo_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Output mapping; the FIFO and the line compare always see raw bytes.
    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        if ((UPPERCASE != 0) && (DATA_WIDTH == 8) &&
            (b >= DATA_WIDTH'(8'h61)) && (b <= DATA_WIDTH'(8'h7A))) begin
            r = b - DATA_WIDTH'(8'h20);
        end else begin
            r = b;
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         lines_q, lines_d;
    logic [OVF_W-1:0]      ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  full_q, full_d;

    logic [DATA_WIDTH-1:0] head_s;
    logic                  handoff_s, slot_free_s, release_s, pop_s, push_s, drop_s;
    logic                  line_inc_s, line_dec_s;

    // Push/pop decisions for this edge.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        handoff_s   = tx_valid_q & tx_data_ready;
        slot_free_s = ~tx_valid_q | handoff_s;
        if (LINE_MODE != 0) begin
            // A full FIFO forces a flush so an over-long line cannot deadlock.
            release_s = (lines_q != {CW{1'b0}}) | (count_q == DEPTH_C);
        end else begin
            release_s = 1'b1;
        end
        pop_s  = slot_free_s & (count_q != {CW{1'b0}}) & release_s;
        // A byte arriving at a full FIFO still fits if the head leaves this edge.
        push_s = rx_data_valid & ((count_q != DEPTH_C) | pop_s);
        drop_s = rx_data_valid & ~push_s;
        line_inc_s = (LINE_MODE != 0) & push_s & (rx_data == LINE_TERM);
        line_dec_s = (LINE_MODE != 0) & pop_s & (head_s == LINE_TERM);
    end

    // Next-state for pointers, occupancy, line counter and overflow counter.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);

        case ({line_inc_s, line_dec_s})
            2'b10:   lines_d = lines_q + CW'(1);
            2'b01:   lines_d = lines_q - CW'(1);
            default: lines_d = lines_q;
        endcase

        // Clear wins over a simultaneous drop.
        if (ovf_clr) begin
            ovf_d = {OVF_W{1'b0}};
        end else if (drop_s && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Output register: load the transformed head, or retire the byte on handoff.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (pop_s) begin
            tx_data_d  = xform(head_s);
            tx_valid_d = 1'b1;
        end else if (handoff_s) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            lines_q    <= {CW{1'b0}};
            ovf_q      <= {OVF_W{1'b0}};
            tx_data_q  <= {DATA_WIDTH{1'b0}};
            tx_valid_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lines_q    <= lines_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            full_q     <= full_d;
        end
    end

    assign rx_data_ready = 1'b1;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign fifo_count    = count_q;
    assign ovf_count     = ovf_q;
    assign fifo_full     = full_q;

endmodule
